// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port unified memory between the instruction-fetch path
// and the load/store path of an RV32 core. Data accesses take priority, and a
// starvation counter forces a fetch grant after MAX_D_BURST data grants made
// while fetch was waiting. A misaligned fetch is answered with a fault pulse
// and never reaches memory.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   if_req_i, if_addr_i            fetch request (held until if_ack_o)
//   if_rdata_o, if_ack_o,
//   if_fault_o                     fetch response (ack/fault are 1-cycle pulses)
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i, d_be_i              load/store request (held until d_ack_o)
//   d_rdata_o, d_ack_o             load/store response
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o,
//   mem_be_o                       registered memory request, held until ready
//   mem_rdata_i, mem_ready_i       memory response
//   busy_o                         a memory transfer is in progress
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  output logic              if_fault_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_be_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_D_BURST);

  state_t            state_q, state_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic [3:0]        memBe_q, memBe_d;
  logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
  logic [DATA_W-1:0] dRdata_q, dRdata_d;
  logic              ifAck_q, ifAck_d;
  logic              dAck_q, dAck_d;
  logic              ifFault_q, ifFault_d;
  logic [3:0]        starveCnt_q, starveCnt_d;

  // A requester keeps req high during its own ack cycle; that cycle must not
  // be mistaken for a fresh request.
  logic ifPending, dPending, fetchWins, ifMisaligned;

  assign ifPending    = if_req_i & ~ifAck_q;
  assign dPending     = d_req_i & ~dAck_q;
  assign fetchWins    = ifPending & (~dPending | (starveCnt_q == MAX_CNT));
  assign ifMisaligned = |if_addr_i[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      memBe_q     <= '0;
      ifRdata_q   <= '0;
      dRdata_q    <= '0;
      ifAck_q     <= 1'b0;
      dAck_q      <= 1'b0;
      ifFault_q   <= 1'b0;
      starveCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      memBe_q     <= memBe_d;
      ifRdata_q   <= ifRdata_d;
      dRdata_q    <= dRdata_d;
      ifAck_q     <= ifAck_d;
      dAck_q      <= dAck_d;
      ifFault_q   <= ifFault_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    memWe_d     = memWe_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    memBe_d     = memBe_q;
    ifRdata_d   = ifRdata_q;
    dRdata_d    = dRdata_q;
    ifAck_d     = 1'b0;
    dAck_d      = 1'b0;
    ifFault_d   = 1'b0;
    starveCnt_d = starveCnt_q;

    unique case (state_q)
      IDLE: begin
        if (fetchWins) begin
          starveCnt_d = '0;
          if (ifMisaligned) begin
            // Answered locally: fault pulse next cycle, memory untouched,
            // and the data side loses this arbitration slot.
            ifAck_d   = 1'b1;
            ifFault_d = 1'b1;
          end else begin
            state_d    = BUSY_IF;
            memWe_d    = 1'b0;
            memAddr_d  = if_addr_i;
            memWdata_d = '0;
            memBe_d    = 4'hF;
          end
        end else if (dPending) begin
          state_d    = BUSY_D;
          memWe_d    = d_we_i;
          memAddr_d  = d_addr_i;
          memWdata_d = d_wdata_i;
          memBe_d    = d_be_i;
          if (ifPending && (starveCnt_q != MAX_CNT)) begin
            starveCnt_d = starveCnt_q + 4'd1;
          end
        end
      end
      BUSY_IF: begin
        if (mem_ready_i) begin
          ifRdata_d = mem_rdata_i;
          ifAck_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ready_i) begin
          if (!memWe_q) begin
            dRdata_d = mem_rdata_i;
          end
          dAck_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Driven straight from the state register so an async reset drops the
  // outstanding request in the same instant.
  assign mem_req_o   = (state_q != IDLE);
  assign busy_o      = (state_q != IDLE);
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;
  assign mem_be_o    = memBe_q;
  assign if_rdata_o  = ifRdata_q;
  assign d_rdata_o   = dRdata_q;
  assign if_ack_o    = ifAck_q;
  assign d_ack_o     = dAck_q;
  assign if_fault_o  = ifFault_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios followed by
// protocol-respecting random traffic, all compared against a transaction-level
// reference model of who owns the memory and what each requester should see.
module tb_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        if_fault_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        busy_o;

  int numChecks = 0;
  int numBad    = 0;

  // Reference model: owner 0 = nobody, 1 = fetch, 2 = data.
  int          mOwner;
  int          mStarve;
  logic        mIfAck, mDAck, mFault, mWe;
  logic [31:0] mIfRdata, mDRdata, mAddr, mWdata;
  logic [3:0]  mBe;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ack_o(if_ack_o), .if_fault_o(if_fault_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_be_i(d_be_i), .d_rdata_o(d_rdata_o),
    .d_ack_o(d_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numBad++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    mOwner = 0; mStarve = 0;
    mIfAck = 0; mDAck = 0; mFault = 0; mWe = 0;
    mIfRdata = '0; mDRdata = '0; mAddr = '0; mWdata = '0; mBe = '0;
  endtask

  task automatic compareAll();
    checkOutput("if_ack", 32'(if_ack_o), 32'(mIfAck));
    checkOutput("d_ack", 32'(d_ack_o), 32'(mDAck));
    checkOutput("if_fault", 32'(if_fault_o), 32'(mFault));
    checkOutput("busy", 32'(busy_o), 32'(mOwner != 0));
    checkOutput("mem_req", 32'(mem_req_o), 32'(mOwner != 0));
    checkOutput("if_rdata", if_rdata_o, mIfRdata);
    checkOutput("d_rdata", d_rdata_o, mDRdata);
    if (mOwner != 0) begin
      checkOutput("mem_addr", mem_addr_o, mAddr);
      checkOutput("mem_we", 32'(mem_we_o), 32'(mWe));
      if (mOwner == 2) begin
        checkOutput("mem_wdata", mem_wdata_o, mWdata);
        checkOutput("mem_be", 32'(mem_be_o), 32'(mBe));
      end
    end
  endtask

  // Drives one cycle of inputs (called at a falling edge), advances the model
  // across the rising edge, then checks outputs at the next falling edge.
  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWdata,
                               input logic [3:0] dBe, input logic memReady,
                               input logic [31:0] memRdata);
    int          nOwner, nStarve;
    logic        nIfAck, nDAck, nFault, nWe;
    logic [31:0] nIfRdata, nDRdata, nAddr, nWdata;
    logic [3:0]  nBe;
    logic        ifWants, dWants;

    if_req_i = ifReq; if_addr_i = ifAddr;
    d_req_i = dReq; d_we_i = dWe; d_addr_i = dAddr; d_wdata_i = dWdata; d_be_i = dBe;
    mem_ready_i = memReady; mem_rdata_i = memRdata;

    nOwner = mOwner; nStarve = mStarve; nWe = mWe;
    nIfRdata = mIfRdata; nDRdata = mDRdata; nAddr = mAddr; nWdata = mWdata; nBe = mBe;
    nIfAck = 0; nDAck = 0; nFault = 0;

    if (mOwner == 0) begin
      ifWants = ifReq && !mIfAck;
      dWants  = dReq && !mDAck;
      if (ifWants && (!dWants || mStarve == MAXB)) begin
        nStarve = 0;
        if ((ifAddr % 4) != 0) begin
          nIfAck = 1; nFault = 1;
        end else begin
          nOwner = 1; nAddr = ifAddr; nWe = 0;
        end
      end else if (dWants) begin
        if (ifWants && mStarve < MAXB) nStarve = mStarve + 1;
        nOwner = 2; nAddr = dAddr; nWe = dWe; nWdata = dWdata; nBe = dBe;
      end
    end else if (memReady) begin
      if (mOwner == 1) begin
        nIfRdata = memRdata; nIfAck = 1;
      end else begin
        if (!mWe) nDRdata = memRdata;
        nDAck = 1;
      end
      nOwner = 0;
    end

    @(posedge clk);
    mOwner = nOwner; mStarve = nStarve; mWe = nWe;
    mIfRdata = nIfRdata; mDRdata = nDRdata; mAddr = nAddr; mWdata = nWdata; mBe = nBe;
    mIfAck = nIfAck; mDAck = nDAck; mFault = nFault;
    @(negedge clk);
    compareAll();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
  endtask

  logic        rIfReq, rDReq, rDWe, rReady;
  logic [31:0] rIfAddr, rDAddr, rDWdata;
  logic [3:0]  rDBe;
  logic [7:0]  rByte;
  logic [1:0]  rLow;

  initial begin
    rst = 1'b1;
    if_req_i = 0; if_addr_i = '0; d_req_i = 0; d_we_i = 0; d_addr_i = '0;
    d_wdata_i = '0; d_be_i = '0; mem_ready_i = 0; mem_rdata_i = '0;
    resetModel();
    @(negedge clk);
    @(negedge clk);
    compareAll();
    checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata_o, 32'h0);
    checkOutput("rst_mem_be", 32'(mem_be_o), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we_o), 32'h0);
    rst = 1'b0;

    $display("[TB] single load, zero wait");
    applyStimulus(0, 32'h0, 1, 0, 32'h10, 32'h0, 4'hF, 0, 32'h0);
    checkOutput("load_memreq_c1", 32'(mem_req_o), 32'h1);
    checkOutput("load_addr", mem_addr_o, 32'h10);
    applyStimulus(0, 32'h0, 1, 0, 32'h10, 32'h0, 4'hF, 1, 32'hDEADBEEF);
    checkOutput("load_ack_c2", 32'(d_ack_o), 32'h1);
    checkOutput("load_data", d_rdata_o, 32'hDEADBEEF);
    checkOutput("load_busy_c2", 32'(busy_o), 32'h0);
    idleCycle();

    $display("[TB] store with two wait states");
    applyStimulus(0, 32'h0, 1, 1, 32'h20, 32'h64, 4'hF, 0, 32'h0);
    applyStimulus(0, 32'h0, 1, 1, 32'h20, 32'h64, 4'hF, 0, 32'h11111111);
    applyStimulus(0, 32'h0, 1, 1, 32'h20, 32'h64, 4'hF, 0, 32'h22222222);
    checkOutput("store_wdata", mem_wdata_o, 32'h64);
    checkOutput("store_memreq_c3", 32'(mem_req_o), 32'h1);
    applyStimulus(0, 32'h0, 1, 1, 32'h20, 32'h64, 4'hF, 1, 32'h33333333);
    checkOutput("store_ack_c4", 32'(d_ack_o), 32'h1);
    checkOutput("store_keeps_rdata", d_rdata_o, 32'hDEADBEEF);
    idleCycle();

    $display("[TB] misaligned fetch");
    applyStimulus(1, 32'h102, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    checkOutput("mis_ack", 32'(if_ack_o), 32'h1);
    checkOutput("mis_fault", 32'(if_fault_o), 32'h1);
    checkOutput("mis_no_memreq", 32'(mem_req_o), 32'h0);
    idleCycle();
    checkOutput("mis_ack_one_cycle", 32'(if_ack_o), 32'h0);

    $display("[TB] ack masking");
    applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hCAFE0001);
    checkOutput("mask_ack", 32'(if_ack_o), 32'h1);
    applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    checkOutput("mask_no_dup", 32'(busy_o), 32'h0);
    applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    checkOutput("mask_regrant", 32'(busy_o), 32'h1);
    applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hCAFE0002);
    idleCycle();

    $display("[TB] simultaneous requests");
    applyStimulus(1, 32'h200, 1, 0, 32'h300, 32'h0, 4'h3, 0, 32'h0);
    checkOutput("both_data_first", mem_addr_o, 32'h300);
    applyStimulus(1, 32'h200, 1, 0, 32'h300, 32'h0, 4'h3, 1, 32'h0BADF00D);
    applyStimulus(1, 32'h200, 1, 0, 32'h300, 32'h0, 4'h3, 0, 32'h0);
    checkOutput("both_fetch_in_dack", mem_addr_o, 32'h200);
    applyStimulus(1, 32'h200, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h12345678);
    idleCycle();

    $display("[TB] reset mid-transaction");
    applyStimulus(0, 32'h0, 1, 0, 32'h40, 32'h0, 4'hF, 0, 32'h0);
    applyStimulus(1, 32'h80, 1, 0, 32'h40, 32'h0, 4'hF, 0, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("rst_drop_memreq", 32'(mem_req_o), 32'h0);
    checkOutput("rst_drop_busy", 32'(busy_o), 32'h0);
    checkOutput("rst_no_dack", 32'(d_ack_o), 32'h0);
    checkOutput("rst_no_ifack", 32'(if_ack_o), 32'h0);
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 32'h80, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    checkOutput("post_rst_fetch", mem_addr_o, 32'h80);
    applyStimulus(1, 32'h80, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hA5A5A5A5);
    idleCycle();

    $display("[TB] random traffic");
    rIfReq = 0; rDReq = 0; rDWe = 0; rIfAddr = '0; rDAddr = '0; rDWdata = '0; rDBe = '0;
    for (int i = 0; i < 600; i++) begin
      if (!(rIfReq && !mIfAck)) begin
        rIfReq = ($urandom_range(0, 2) != 0);
        rByte  = 8'($urandom);
        rLow   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        rIfAddr = {22'h0, rByte, rLow};
      end
      if (!(rDReq && !mDAck)) begin
        rDReq   = ($urandom_range(0, 2) != 0);
        rDWe    = 1'($urandom);
        rDAddr  = $urandom;
        rDWdata = $urandom;
        rDBe    = 4'($urandom);
      end
      rReady = 1'($urandom);
      applyStimulus(rIfReq, rIfAddr, rDReq, rDWe, rDAddr, rDWdata, rDBe,
                    rReady, $urandom);
      checkOutput("acks_exclusive", 32'(if_ack_o & d_ack_o), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", numChecks, numBad);
    $finish;
  end

endmodule
